// File: rtl/io_bus_pkg.sv
// io_bus_pkg: region codes, chip-select bit indices, controller state and parameter defaults.
package io_bus_pkg;
    localparam logic [3:0] REG_RAM_MAX  = 4'hA;
    localparam logic [3:0] REG_UNMAPPED = 4'hB;
    localparam logic [3:0] REG_AUDIO    = 4'hC;
    localparam logic [3:0] REG_GFX      = 4'hD;
    localparam logic [3:0] REG_SPART    = 4'hE;
    localparam logic [3:0] REG_PS2      = 4'hF;
    localparam int CS_RAM   = 0;
    localparam int CS_AUDIO = 1;
    localparam int CS_GFX   = 2;
    localparam int CS_SPART = 3;
    localparam int CS_PS2   = 4;
    localparam int RAM_WAIT_DEF = 2;
    localparam int TIMEOUT_DEF  = 255;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_e;
endpackage

// File: rtl/io_addr_decode.sv
// io_addr_decode: maps an address region nibble to a one-hot chip select and an unmapped flag.
module io_addr_decode
    import io_bus_pkg::*;
(
    input  logic [3:0] region_i,
    output logic [4:0] cs_o,
    output logic       unmapped_o
);
    always_comb begin
        cs_o = '0;
        unmapped_o = 1'b0;
        if (region_i <= REG_RAM_MAX) cs_o[CS_RAM] = 1'b1;
        else if (region_i == REG_AUDIO) cs_o[CS_AUDIO] = 1'b1;
        else if (region_i == REG_GFX) cs_o[CS_GFX] = 1'b1;
        else if (region_i == REG_SPART) cs_o[CS_SPART] = 1'b1;
        else if (region_i == REG_PS2) cs_o[CS_PS2] = 1'b1;
        else unmapped_o = region_i == REG_UNMAPPED;
    end
endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: CPU-to-peripheral bus controller with fixed-latency RAM and acked peripherals.
// Define IO_BUS_TIMEOUT_EN to abort unacknowledged peripheral accesses after TIMEOUT cycles.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int RAM_WAIT = RAM_WAIT_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic [15:0] cpu_rdata,
    output logic [4:0]  cs,
    output logic        dev_read,
    output logic        dev_write,
    output logic [11:0] dev_addr,
    output logic [15:0] dev_wdata,
    input  logic [15:0] dev_rdata,
    input  logic        dev_ack
);
    state_e      state_q, state_d;
    logic [4:0]  cs_q, cs_d, dec_cs;
    logic [11:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d, dec_unmapped, is_ram;

    io_addr_decode u_dec (
        .region_i  (cpu_addr[15:12]),
        .cs_o      (dec_cs),
        .unmapped_o(dec_unmapped)
    );

    assign is_ram = cs_q[CS_RAM];

    always_comb begin
        state_d = state_q;
        cs_d = cs_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d = we_q;
        cnt_d = cnt_q;
        unique case (state_q)
            S_IDLE: if (cpu_req) begin
                addr_d = cpu_addr[11:0];
                wdata_d = cpu_wdata;
                we_d = cpu_we;
                cs_d = dec_cs;
                cnt_d = '0;
                state_d = dec_unmapped ? S_ERR : S_ACCESS;
            end
            S_ACCESS: begin
                if (is_ram ? cnt_q == 8'(RAM_WAIT - 1) : dev_ack) begin
                    state_d = S_DONE;
                    rdata_d = we_q ? rdata_q : dev_rdata;
                end
`ifdef IO_BUS_TIMEOUT_EN
                else if (!is_ram && cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    rdata_d = we_q ? rdata_q : 16'hFFFF;
                end
`endif
                // saturate so an indefinite peripheral wait never wraps the counter
                else cnt_d = cnt_q == 8'(TIMEOUT) ? cnt_q : cnt_q + 8'd1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cs_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cs_q <= cs_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q <= we_d;
            cnt_q <= cnt_d;
        end
    end

    assign cs = state_q == S_ACCESS ? cs_q : '0;
    assign dev_read = state_q == S_ACCESS && !we_q;
    assign dev_write = state_q == S_ACCESS && we_q;
    assign dev_addr = addr_q;
    assign dev_wdata = wdata_q;
    assign cpu_ready = state_q == S_DONE || state_q == S_ERR;
    assign cpu_err = state_q == S_ERR;
    assign cpu_rdata = rdata_q;
endmodule
